imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 32'd1024, giving instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a load session; sampled only in IDLE.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data carries a valid byte.
REQ-006 The block SHALL have port in_data, input, 8 bits: byte stream carrying the length header, then instruction words.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte; a byte transfers in a cycle where in_valid and in_ready are both 1.
REQ-008 The block SHALL have port mem_we, output, 1 bit: instruction memory write strobe.
REQ-009 The block SHALL have port mem_addr, output, 32 bits: byte address of the write, always word-aligned.
REQ-010 The block SHALL have port mem_wdata, output, 32 bits: instruction word to write.
REQ-011 The block SHALL have port busy, output, 1 bit: a load is in progress; holds the core in reset.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 The block SHALL have port err, output, 1 bit: sticky length error; cleared on the next accepted start or on reset.

Function
REQ-014 The state machine SHALL have states IDLE, LEN, DATA and DONE.
REQ-015 In IDLE, start=1 SHALL move the block to LEN and clear the byte counter, the word counter and err.
REQ-016 In IDLE, start=0 SHALL leave all state unchanged.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 in_ready SHALL be 1 exactly in LEN and DATA, and 0 in IDLE and DONE.
REQ-019 LEN SHALL accept 4 bytes, little-endian, into a 32-bit word count len (first byte = bits 7:0).
REQ-020 On the 4th length byte, the next state SHALL be: DONE if len==0; IDLE with err=1 if len>MEM_SIZE; otherwise DATA.
REQ-021 len==MEM_SIZE SHALL be accepted as valid.
REQ-022 DATA SHALL assemble each group of 4 accepted bytes little-endian into one word.
REQ-023 When the 4th byte of word k is accepted at edge T, in the following cycle the outputs SHALL be mem_we=1, mem_wdata=word, mem_addr=4*k, with mem_we high for exactly that one cycle.
REQ-024 A byte accepted in the same cycle as mem_we=1 SHALL go into the next word and SHALL NOT corrupt mem_wdata.
REQ-025 On acceptance of the final byte of word len-1, the next state SHALL be DONE, and the final mem_we SHALL occur in the DONE cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in LEN, DATA and DONE, and 0 in IDLE.
REQ-028 mem_we SHALL never assert during LEN or in IDLE.
REQ-029 mem_addr and mem_wdata SHALL hold their last values between writes.
REQ-030 Gaps in in_valid SHALL stall the block without altering its counters or the assembled data.

Reset
REQ-031 On rst=1 at a clock edge, the state SHALL become IDLE and all counters and the partial word SHALL be cleared.
REQ-032 Reset values SHALL be in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
REQ-033 Reset mid-session SHALL discard any partial word and SHALL produce no further mem_we.
REQ-034 rst SHALL take priority over start and over any byte transfer in the same cycle.

Verification
REQ-035 Scenario: reset, start, then bytes 02 00 00 00 EF BE AD DE 78 56 34 12 with in_valid held high -> writes 0xDEADBEEF @0x0 and then 0x12345678 @0x4; done=1 in the same cycle as the second mem_we; busy=0 in the next cycle.
REQ-036 Scenario: start, then bytes 00 00 00 00 -> DONE in the next cycle with done=1 and no mem_we; then IDLE.
REQ-037 Scenario: MEM_SIZE=1024, start, then bytes 01 04 00 00 (len=1025) -> err=1, IDLE, busy=0, in_ready=0, no mem_we; a later start clears err.
REQ-038 Scenario: the same stream as REQ-035 with in_valid deasserted randomly (including in mem_we cycles) -> identical writes and addresses.
REQ-039 Scenario: start, len=1, data bytes 11 22, then rst -> no mem_we, IDLE; a new session with len=1 and bytes AA BB CC DD -> writes 0xDDCCBBAA @0x0.
REQ-040 Scenario: start asserted during DATA -> ignored; counters and writes unaffected.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a little-endian word count followed by
// instruction words over a byte stream and writes them to memory.
module imem_loader #(
    parameter int unsigned MEM_SIZE = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] len;
    logic [31:0] partial;
    logic        accept;
    logic        last_byte;
    logic [31:0] word_full;

    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == 2'd3);
    // Shift register view: the incoming byte lands in the top lane.
    assign word_full = {in_data, partial[31:8]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (accept && last_byte) begin
                    if (word_full == 32'd0) begin
                        state_nxt = DONE;
                    end else if (word_full > 32'(MEM_SIZE)) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && last_byte && (word_cnt + 32'd1 == len)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LEN:  begin in_ready = 1'b1; busy = 1'b1; end
            DATA: begin in_ready = 1'b1; busy = 1'b1; end
            DONE: begin busy = 1'b1; done = 1'b1; end
            default: begin end
        endcase
    end

    // Byte assembly, counters and the registered memory write port
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= 32'd0;
            len       <= 32'd0;
            partial   <= 32'd0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                byte_cnt <= 2'd0;
                word_cnt <= 32'd0;
                err      <= 1'b0;
            end
            if (accept) begin
                partial  <= word_full;
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    if (state == LEN) begin
                        len <= word_full;
                        if (word_full > 32'(MEM_SIZE)) begin
                            err <= 1'b1;
                        end
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt << 2;
                        mem_wdata <= word_full;
                        word_cnt  <= word_cnt + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: session timing, length boundaries,
// stalls, mid-session reset and start-while-busy.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int bad_we = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(.MEM_SIZE(32'd1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write log, plus any strobe seen outside a session
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (!busy) bad_we++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        step(gap);
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 50 && !in_ready; n++) step(1);
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        else step(1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step(2);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        step(2);
        check("idle_hold_busy", 32'(busy), 0);

        // Two-word load, back-to-back bytes
        clear_log();
        do_start();
        check("len_in_ready", 32'(in_ready), 1);
        check("len_busy", 32'(busy), 1);
        send_word(32'd2, 0);
        send_word(32'hDEADBEEF, 0);
        send_word(32'h12345678, 0);
        check("s1_last_we", 32'(mem_we), 1);
        check("s1_done", 32'(done), 1);
        check("s1_last_addr", mem_addr, 32'h4);
        check("s1_last_data", mem_wdata, 32'h12345678);
        check("s1_done_ready", 32'(in_ready), 0);
        step(1);
        check("s1_busy_after", 32'(busy), 0);
        check("s1_done_after", 32'(done), 0);
        check("s1_we_after", 32'(mem_we), 0);
        check("s1_addr_hold", mem_addr, 32'h4);
        check("s1_data_hold", mem_wdata, 32'h12345678);
        check("s1_nwrites", 32'(wa.size()), 2);
        check("s1_w0_addr", wa[0], 32'h0);
        check("s1_w0_data", wd[0], 32'hDEADBEEF);
        check("s1_w1_addr", wa[1], 32'h4);
        check("s1_w1_data", wd[1], 32'h12345678);

        // Zero-length header
        clear_log();
        do_start();
        send_word(32'd0, 0);
        check("s2_done", 32'(done), 1);
        check("s2_busy", 32'(busy), 1);
        check("s2_we", 32'(mem_we), 0);
        step(1);
        check("s2_idle_busy", 32'(busy), 0);
        check("s2_nwrites", 32'(wa.size()), 0);

        // Oversize header (1025 words)
        clear_log();
        do_start();
        send_word(32'd1025, 0);
        check("s3_err", 32'(err), 1);
        check("s3_busy", 32'(busy), 0);
        check("s3_in_ready", 32'(in_ready), 0);
        check("s3_done", 32'(done), 0);
        step(3);
        check("s3_err_sticky", 32'(err), 1);
        check("s3_nwrites", 32'(wa.size()), 0);
        do_start();
        check("s3_err_cleared", 32'(err), 0);
        check("s3_restart_busy", 32'(busy), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // Same two-word load with random stalls
        clear_log();
        do_start();
        send_word(32'd2, 3);
        send_word(32'hDEADBEEF, 3);
        send_word(32'h12345678, 3);
        check("s4_done", 32'(done), 1);
        step(1);
        check("s4_nwrites", 32'(wa.size()), 2);
        check("s4_w0_addr", wa[0], 32'h0);
        check("s4_w0_data", wd[0], 32'hDEADBEEF);
        check("s4_w1_addr", wa[1], 32'h4);
        check("s4_w1_data", wd[1], 32'h12345678);

        // Reset mid-word, asserted together with start
        clear_log();
        do_start();
        send_word(32'd1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1; start = 1'b1;
        step(1);
        rst = 1'b0; start = 1'b0;
        check("s5_busy", 32'(busy), 0);
        check("s5_in_ready", 32'(in_ready), 0);
        check("s5_addr_rst", mem_addr, 0);
        check("s5_data_rst", mem_wdata, 0);
        step(3);
        check("s5_nwrites", 32'(wa.size()), 0);
        do_start();
        send_word(32'd1, 0);
        send_word(32'hDDCCBBAA, 0);
        check("s5_done", 32'(done), 1);
        step(1);
        check("s5_nwrites2", 32'(wa.size()), 1);
        check("s5_w0_addr", wa[0], 32'h0);
        check("s5_w0_data", wd[0], 32'hDDCCBBAA);

        // start held high during DATA is ignored
        clear_log();
        do_start();
        send_word(32'd2, 0);
        send_word(32'hCAFEF00D, 0);
        start = 1'b1;
        send_byte(8'h01, 1);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        start = 1'b0;
        send_byte(8'h04, 0);
        check("s6_done", 32'(done), 1);
        step(2);
        check("s6_busy", 32'(busy), 0);
        check("s6_nwrites", 32'(wa.size()), 2);
        check("s6_w0_data", wd[0], 32'hCAFEF00D);
        check("s6_w1_addr", wa[1], 32'h4);
        check("s6_w1_data", wd[1], 32'h04030201);

        // Full-capacity load: len == MEM_SIZE is accepted
        clear_log();
        do_start();
        send_word(32'd1024, 0);
        check("s7_not_err", 32'(err), 0);
        for (int i = 0; i < 1024; i++) send_word({16'hC35A, 16'(i)}, 0);
        check("s7_done", 32'(done), 1);
        check("s7_last_addr", mem_addr, 32'hFFC);
        step(1);
        check("s7_nwrites", 32'(wa.size()), 1024);
        for (int i = 0; i < 1024 && i < wa.size(); i++) begin
            check("s7_addr", wa[i], 32'(4 * i));
            check("s7_data", wd[i], {16'hC35A, 16'(i)});
        end

        check("we_outside_session", 32'(bad_we), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
